// File: rtl/operand_stage.sv
// Operand-fetch stage: register file plus a one-entry registered output toward the ALU.
// Optional macro OPERAND_STAGE_BYPASS_EN forwards a same-edge write-back into the captured operands.
module operand_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rs1,
  input  logic [RA_W-1:0] in_rs2,
  input  logic [RA_W-1:0] in_rd,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [2:0]      in_op,
  input  logic            in_cont,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [2:0]      out_op,
  output logic            out_cont,
  output logic [RA_W-1:0] out_rd
);

  localparam int unsigned NREG = 1 << RA_W;

  logic [XLEN-1:0] rf_q [NREG];

  logic            valid_q, valid_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            cont_q, cont_d;
  logic [RA_W-1:0] rd_q, rd_d;

  logic            accept;
  logic            wb_live;
  logic [XLEN-1:0] rs1_val, rs2_val;

  // Entry 0 is never written, so it stays at its reset value of zero.
  assign wb_live = wb_en && (wb_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_live) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs1_val = (in_rs1 == '0) ? '0 : rf_q[in_rs1];
    rs2_val = (in_rs2 == '0) ? '0 : rf_q[in_rs2];
`ifdef OPERAND_STAGE_BYPASS_EN
    if (wb_live && (wb_addr == in_rs1)) rs1_val = wb_data;
    if (wb_live && (wb_addr == in_rs2)) rs2_val = wb_data;
`endif
  end

  assign in_ready = !rst && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cont_d  = cont_q;
    rd_d    = rd_q;
    if (accept) begin
      valid_d = 1'b1;
      a_d     = rs1_val;
      b_d     = in_use_imm ? in_imm : rs2_val;
      op_d    = in_op;
      cont_d  = in_cont;
      rd_d    = in_rd;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cont_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cont_q  <= cont_d;
      rd_q    <= rd_d;
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_op    = op_q;
  assign out_cont  = cont_q;
  assign out_rd    = rd_q;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed vector table followed by random traffic against a reference model.
module tb_operand_stage;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

`ifdef OPERAND_STAGE_BYPASS_EN
  localparam logic [31:0] BYP_A = 32'h22;
`else
  localparam logic [31:0] BYP_A = 32'h11;
`endif

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, in_use_imm, in_cont, wb_en, out_valid, out_ready, out_cont;
  logic [RA_W-1:0] in_rs1, in_rs2, in_rd, wb_addr, out_rd;
  logic [XLEN-1:0] in_imm, wb_data, out_a, out_b;
  logic [2:0]      in_op, out_op;

  operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_op(in_op), .in_cont(in_cont),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_op(out_op), .out_cont(out_cont), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs first, then expectations: e_rdy is in_ready before the edge, the rest after it.
  typedef struct {
    logic [31:0] rst, iv, rs1, rs2, rd, imm, uimm, op, cont, wbe, wba, wbd, ordy;
    logic [31:0] e_rdy, e_val, e_chk, e_a, e_b, e_op, e_cont, e_rd;
  } vec_t;

  vec_t tbl[17];

  task automatic drive(input logic [31:0] r, iv, rs1, rs2, rd, imm, uimm, op, cont,
                       wbe, wba, wbd, ordy);
    rst = r[0]; in_valid = iv[0]; in_rs1 = rs1[RA_W-1:0]; in_rs2 = rs2[RA_W-1:0];
    in_rd = rd[RA_W-1:0]; in_imm = imm; in_use_imm = uimm[0]; in_op = op[2:0];
    in_cont = cont[0]; wb_en = wbe[0]; wb_addr = wba[RA_W-1:0]; wb_data = wbd;
    out_ready = ordy[0];
  endtask

  task automatic check_outs(input string tag, input logic [31:0] v, a, b, op, cont, rd,
                            input bit data);
    chk({tag, " out_valid"}, {31'b0, out_valid}, v);
    if (data) begin
      chk({tag, " out_a"}, out_a, a);
      chk({tag, " out_b"}, out_b, b);
      chk({tag, " out_op"}, {29'b0, out_op}, op);
      chk({tag, " out_cont"}, {31'b0, out_cont}, cont);
      chk({tag, " out_rd"}, {27'b0, out_rd}, rd);
    end
  endtask

  // Reference model state
  logic [31:0] mrf [32];
  logic        m_valid, m_zero, m_cont;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [4:0]  m_rd;

  function automatic logic [31:0] mread(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
`ifdef OPERAND_STAGE_BYPASS_EN
    if (wb_en && wb_addr == addr) return wb_data;
`endif
    return mrf[addr];
  endfunction

  initial begin
    //         rst iv rs1 rs2 rd imm          uimm op cont wbe wba wbd           ordy | rdy val chk a      b             op cont rd
    tbl[0]  = '{1, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0,            0,   0, 0, 1, 0,     0,            0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0,           0, 0, 0, 1, 3, 3,            1,   1, 0, 1, 0,     0,            0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0,           0, 0, 0, 1, 4, 'hFFFFFFFF,   1,   1, 0, 1, 0,     0,            0, 0, 0};
    tbl[3]  = '{0, 1, 3, 4, 7, 0,           0, 0, 0, 0, 0, 0,            1,   1, 1, 1, 3,     'hFFFFFFFF,   0, 0, 7};
    tbl[4]  = '{0, 0, 0, 0, 0, 0,           0, 0, 0, 1, 0, 'h12345678,   1,   1, 0, 0, 0,     0,            0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 2, 0,           0, 5, 1, 0, 0, 0,            0,   1, 1, 1, 0,     0,            5, 1, 2};
    tbl[6]  = '{0, 1, 3, 4, 9, 0,           0, 1, 0, 0, 0, 0,            0,   0, 1, 1, 0,     0,            5, 1, 2};
    tbl[7]  = '{0, 1, 3, 4, 9, 0,           0, 1, 0, 0, 0, 0,            0,   0, 1, 1, 0,     0,            5, 1, 2};
    tbl[8]  = '{0, 1, 3, 4, 9, 0,           0, 1, 0, 0, 0, 0,            0,   0, 1, 1, 0,     0,            5, 1, 2};
    tbl[9]  = '{0, 1, 3, 4, 9, 0,           0, 1, 0, 0, 0, 0,            1,   1, 1, 1, 3,     'hFFFFFFFF,   1, 0, 9};
    tbl[10] = '{0, 0, 0, 0, 0, 0,           0, 0, 0, 1, 5, 'h11,         1,   1, 0, 0, 0,     0,            0, 0, 0};
    tbl[11] = '{0, 1, 5, 0, 5, 0,           0, 2, 0, 1, 5, 'h22,         1,   1, 1, 1, BYP_A, 0,            2, 0, 5};
    tbl[12] = '{0, 1, 5, 4, 1, 'hFFFFFFF0,  1, 3, 1, 0, 0, 0,            1,   1, 1, 1, 'h22,  'hFFFFFFF0,   3, 1, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0,            0,   0, 1, 1, 'h22,  'hFFFFFFF0,   3, 1, 1};
    tbl[14] = '{1, 1, 3, 4, 6, 0,           0, 7, 1, 1, 6, 'h77,         0,   0, 0, 1, 0,     0,            0, 0, 0};
    tbl[15] = '{0, 1, 3, 6, 3, 0,           0, 0, 0, 0, 0, 0,            1,   1, 1, 1, 0,     0,            0, 0, 3};
    tbl[16] = '{0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0,            1,   1, 0, 0, 0,     0,            0, 0, 0};

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].rst, tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm,
            tbl[i].uimm, tbl[i].op, tbl[i].cont, tbl[i].wbe, tbl[i].wba, tbl[i].wbd,
            tbl[i].ordy);
      #1;
      chk({tag, " in_ready"}, {31'b0, in_ready}, tbl[i].e_rdy);
      @(posedge clk);
      @(negedge clk);
      check_outs(tag, tbl[i].e_val, tbl[i].e_a, tbl[i].e_b, tbl[i].e_op, tbl[i].e_cont,
                 tbl[i].e_rd, tbl[i].e_val[0] || tbl[i].e_chk[0]);
    end

    // Random traffic; the first cycle is a reset so the model starts in sync.
    for (int c = 0; c < 3000; c++) begin
      logic        exp_rdy;
      logic [31:0] r;
      string       tag;
      tag = $sformatf("rnd%0d", c);
      r = (c == 0 || $urandom_range(39) == 0) ? 32'd1 : 32'd0;
      drive(r, {31'b0, 1'($urandom_range(3) != 0)}, $urandom_range(7), $urandom_range(7),
            $urandom_range(31), $urandom, {31'b0, 1'($urandom_range(3) == 0)},
            $urandom_range(7), $urandom_range(1), $urandom_range(1), $urandom_range(7),
            $urandom, {31'b0, 1'($urandom_range(9) < 7)});
      exp_rdy = !rst && (!m_valid || out_ready);
      #1;
      chk({tag, " in_ready"}, {31'b0, in_ready}, {31'b0, exp_rdy});
      @(posedge clk);
      if (rst) begin
        for (int k = 0; k < 32; k++) mrf[k] = 32'h0;
        m_valid = 1'b0; m_zero = 1'b1; m_a = 0; m_b = 0; m_op = 0; m_cont = 0; m_rd = 0;
      end else begin
        if (in_valid && exp_rdy) begin
          m_a     = mread(in_rs1);
          m_b     = in_use_imm ? in_imm : mread(in_rs2);
          m_op    = in_op;
          m_cont  = in_cont;
          m_rd    = in_rd;
          m_valid = 1'b1;
          m_zero  = 1'b0;
        end else if (out_ready) begin
          m_valid = 1'b0;
        end
        if (wb_en && wb_addr != 5'd0) mrf[wb_addr] = wb_data;
      end
      @(negedge clk);
      check_outs(tag, {31'b0, m_valid}, m_a, m_b, {29'b0, m_op}, {31'b0, m_cont},
                 {27'b0, m_rd}, m_valid || m_zero);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
